// File: rtl/kamus_pkg.sv
// Shared types for the kamus-v write-back stage: write-back source select, PC source select, MEM/WB payload.
// No logic here; widths are fixed by the encodings below.
package kamus_pkg;

    localparam int KAMUS_CNT_W = 64;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        IA_SEL_PC4    = 2'b00,
        IA_SEL_BRANCH = 2'b01,
        IA_SEL_JALR   = 2'b10,
        IA_SEL_TRAP   = 2'b11
    } instr_addr_sel_state_e;

    typedef struct packed {
        logic [31:0]           ex_rslt;
        logic [31:0]           l1d_rd_data;
        wb_sel_e               wb_sel;
        logic [4:0]            rd_addr;
        logic                  regfile_wr_en;
        logic [31:0]           next_pc;
        logic                  is_branch_taken;
        instr_addr_sel_state_e instr_addr_sel;
    } memwb_t;

endpackage

// File: rtl/kamus_memwb_reg.sv
// MEM/WB pipeline register: one-cycle capture of a W-bit payload plus valid bit.
// stall holds the entry; flush clears valid and wins over stall; reset wins over both.
module kamus_memwb_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic         valid_in,
    input  logic [W-1:0] data_in,
    output logic         valid_out,
    output logic [W-1:0] data_out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (flush) begin
            // Payload is don't-care once invalid; keep it held under stall so outputs stay quiet.
            valid_out <= 1'b0;
            if (!stall) begin
                data_out <= data_in;
            end
        end else if (!stall) begin
            valid_out <= valid_in;
            data_out  <= data_in;
        end
    end

endmodule

// File: rtl/kamus_wb.sv
// Write-back stage: MEM/WB register, write-back mux, redirect, retired counter; outputs 1 cycle after capture.
// stall_i holds all outputs (rf write repeats harmlessly); KAMUS_WB_FWD_EN adds a one-cycle last-write buffer.
module kamus_wb
    import kamus_pkg::*;
#(
    parameter int CNT_W = KAMUS_CNT_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [31:0]           ex_rslt_i,
    input  logic [31:0]           l1d_rd_data_i,
    input  logic [1:0]            wb_mux_sel_i,
    input  logic [4:0]            rd_addr_i,
    input  logic                  regfile_wr_en_i,
    input  logic [31:0]           next_pc_i,
    input  logic                  is_branch_taken_i,
    input  instr_addr_sel_state_e instr_addr_sel_i,
    output logic                  rf_wr_en_o,
    output logic [4:0]            rf_wr_addr_o,
    output logic [31:0]           rf_wr_data_o,
    output logic                  pc_redirect_o,
    output logic [31:0]           redirect_pc_o,
    output instr_addr_sel_state_e instr_addr_sel_o,
    output logic                  wb_valid_o,
    output logic [CNT_W-1:0]      retired_cnt_o
`ifdef KAMUS_WB_FWD_EN
    ,
    output logic                  fwd_valid_o,
    output logic [4:0]            fwd_rd_addr_o,
    output logic [31:0]           fwd_data_o
`endif
);

    memwb_t memwb_d;
    memwb_t memwb_q;
    logic   entry_vld;

    always_comb begin
        memwb_d                 = '0;
        memwb_d.ex_rslt         = ex_rslt_i;
        memwb_d.l1d_rd_data     = l1d_rd_data_i;
        memwb_d.wb_sel          = wb_sel_e'(wb_mux_sel_i);
        memwb_d.rd_addr         = rd_addr_i;
        memwb_d.regfile_wr_en   = regfile_wr_en_i;
        memwb_d.next_pc         = next_pc_i;
        memwb_d.is_branch_taken = is_branch_taken_i;
        memwb_d.instr_addr_sel  = instr_addr_sel_i;
    end

    kamus_memwb_reg #(
        .W ($bits(memwb_t))
    ) u_memwb_reg (
        .clk       (clk_i),
        .rst       (rst_i),
        .stall     (stall_i),
        .flush     (flush_i),
        .valid_in  (valid_i),
        .data_in   (memwb_d),
        .valid_out (entry_vld),
        .data_out  (memwb_q)
    );

    always_comb begin
        rf_wr_data_o = 32'h0;
        unique case (memwb_q.wb_sel)
            WB_ALU:  rf_wr_data_o = memwb_q.ex_rslt;
            WB_MEM:  rf_wr_data_o = memwb_q.l1d_rd_data;
            WB_PC4:  rf_wr_data_o = memwb_q.next_pc;
            default: rf_wr_data_o = 32'h0;
        endcase
    end

    // x0 is hardwired; never strobe a write to it.
    assign rf_wr_en_o       = entry_vld & memwb_q.regfile_wr_en & (memwb_q.rd_addr != 5'd0);
    assign rf_wr_addr_o     = memwb_q.rd_addr;
    assign pc_redirect_o    = entry_vld & memwb_q.is_branch_taken;
    assign redirect_pc_o    = memwb_q.next_pc;
    assign instr_addr_sel_o = memwb_q.instr_addr_sel;
    assign wb_valid_o       = entry_vld;

    // An entry retires on the edge it leaves the stage, so a held (stalled) entry counts once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retired_cnt_o <= '0;
        end else if (entry_vld && !stall_i) begin
            retired_cnt_o <= retired_cnt_o + CNT_W'(1);
        end
    end

`ifdef KAMUS_WB_FWD_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            fwd_valid_o   <= 1'b0;
            fwd_rd_addr_o <= 5'd0;
            fwd_data_o    <= 32'h0;
        end else if (!stall_i) begin
            fwd_valid_o <= rf_wr_en_o;
            if (rf_wr_en_o) begin
                fwd_rd_addr_o <= rf_wr_addr_o;
                fwd_data_o    <= rf_wr_data_o;
            end
        end else begin
            // Register file keeps rewriting during a stall; only the first cycle needs the bypass.
            fwd_valid_o <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_kamus_wb.sv
// Directed bench for kamus_wb with a 4-bit retired counter so wrap-around is reachable.
module tb_kamus_wb;
    import kamus_pkg::*;

    localparam int CW = 4;

    logic                  clk = 1'b0;
    logic                  rst, stall, flush, valid;
    logic [31:0]           ex_rslt, ld_data, next_pc;
    logic [1:0]            sel;
    logic [4:0]            rd;
    logic                  we, br;
    instr_addr_sel_state_e ia_sel;
    logic                  rf_wr_en, pc_redirect, wb_valid;
    logic [4:0]            rf_wr_addr;
    logic [31:0]           rf_wr_data, redirect_pc;
    instr_addr_sel_state_e ia_sel_o;
    logic [CW-1:0]         cnt;
`ifdef KAMUS_WB_FWD_EN
    logic                  fwd_valid;
    logic [4:0]            fwd_rd;
    logic [31:0]           fwd_data;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    kamus_wb #(.CNT_W(CW)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .stall_i           (stall),
        .flush_i           (flush),
        .valid_i           (valid),
        .ex_rslt_i         (ex_rslt),
        .l1d_rd_data_i     (ld_data),
        .wb_mux_sel_i      (sel),
        .rd_addr_i         (rd),
        .regfile_wr_en_i   (we),
        .next_pc_i         (next_pc),
        .is_branch_taken_i (br),
        .instr_addr_sel_i  (ia_sel),
        .rf_wr_en_o        (rf_wr_en),
        .rf_wr_addr_o      (rf_wr_addr),
        .rf_wr_data_o      (rf_wr_data),
        .pc_redirect_o     (pc_redirect),
        .redirect_pc_o     (redirect_pc),
        .instr_addr_sel_o  (ia_sel_o),
        .wb_valid_o        (wb_valid),
        .retired_cnt_o     (cnt)
`ifdef KAMUS_WB_FWD_EN
        ,
        .fwd_valid_o       (fwd_valid),
        .fwd_rd_addr_o     (fwd_rd),
        .fwd_data_o        (fwd_data)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [4:0] r, input logic w,
                         input logic [31:0] ex, input logic [31:0] ld, input logic [31:0] pc,
                         input logic b, input instr_addr_sel_state_e ia);
        valid = v; sel = s; rd = r; we = w; ex_rslt = ex; ld_data = ld; next_pc = pc; br = b; ia_sel = ia;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, IA_SEL_PC4);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 2'b10, 5'd31, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b1, IA_SEL_TRAP);
        tick();
        tick();
        rst = 1'b0;
        idle();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", wb_valid); end
        checks++; if (rf_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", rf_wr_en); end
        checks++; if (rf_wr_addr !== 5'd0) begin failures++; $display("FAIL reset_wr_addr got=%0d exp=0", rf_wr_addr); end
        checks++; if (rf_wr_data !== 32'h0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0", rf_wr_data); end
        checks++; if (pc_redirect !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%b exp=0", pc_redirect); end
        checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
        checks++; if (ia_sel_o !== IA_SEL_PC4) begin failures++; $display("FAIL reset_ia_sel got=%0d exp=0", ia_sel_o); end
        checks++; if (cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
`ifdef KAMUS_WB_FWD_EN
        checks++; if (fwd_valid !== 1'b0) begin failures++; $display("FAIL reset_fwd_valid got=%b exp=0", fwd_valid); end
`endif
    endtask

    task automatic test_alu_write();
        drive(1'b1, 2'b00, 5'd5, 1'b1, 32'h1234, 32'hBAD0, 32'h44, 1'b0, IA_SEL_PC4);
        tick();
        idle();
        checks++; if (rf_wr_en !== 1'b1) begin failures++; $display("FAIL alu_wr_en got=%b exp=1", rf_wr_en); end
        checks++; if (rf_wr_addr !== 5'd5) begin failures++; $display("FAIL alu_wr_addr got=%0d exp=5", rf_wr_addr); end
        checks++; if (rf_wr_data !== 32'h1234) begin failures++; $display("FAIL alu_wr_data got=%h exp=1234", rf_wr_data); end
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL alu_valid got=%b exp=1", wb_valid); end
        tick();
        checks++; if (cnt !== 4'd1) begin failures++; $display("FAIL alu_cnt got=%0d exp=1", cnt); end
        checks++; if (rf_wr_en !== 1'b0) begin failures++; $display("FAIL alu_bubble_wr_en got=%b exp=0", rf_wr_en); end
    endtask

    task automatic test_x0();
        drive(1'b1, 2'b00, 5'd0, 1'b1, 32'hAAAA, 32'h0, 32'h0, 1'b0, IA_SEL_PC4);
        tick();
        idle();
        checks++; if (rf_wr_en !== 1'b0) begin failures++; $display("FAIL x0_wr_en got=%b exp=0", rf_wr_en); end
        checks++; if (rf_wr_data !== 32'hAAAA) begin failures++; $display("FAIL x0_wr_data got=%h exp=aaaa", rf_wr_data); end
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL x0_valid got=%b exp=1", wb_valid); end
        tick();
        checks++; if (cnt !== 4'd2) begin failures++; $display("FAIL x0_cnt got=%0d exp=2", cnt); end
    endtask

    task automatic test_stall_flush();
        drive(1'b1, 2'b01, 5'd9, 1'b1, 32'h1111, 32'hDEADBEEF, 32'h0, 1'b0, IA_SEL_PC4);
        tick();
        checks++; if (rf_wr_data !== 32'hDEADBEEF) begin failures++; $display("FAIL load_wr_data got=%h exp=deadbeef", rf_wr_data); end
        stall = 1'b1;
        drive(1'b1, 2'b00, 5'd3, 1'b1, 32'h99, 32'h0, 32'h0, 1'b1, IA_SEL_JALR);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rf_wr_data !== 32'hDEADBEEF) begin failures++; $display("FAIL stall_wr_data[%0d] got=%h exp=deadbeef", i, rf_wr_data); end
            checks++; if (rf_wr_addr !== 5'd9) begin failures++; $display("FAIL stall_wr_addr[%0d] got=%0d exp=9", i, rf_wr_addr); end
            checks++; if (rf_wr_en !== 1'b1) begin failures++; $display("FAIL stall_wr_en[%0d] got=%b exp=1", i, rf_wr_en); end
            checks++; if (pc_redirect !== 1'b0) begin failures++; $display("FAIL stall_redirect[%0d] got=%b exp=0", i, pc_redirect); end
            checks++; if (cnt !== 4'd2) begin failures++; $display("FAIL stall_cnt[%0d] got=%0d exp=2", i, cnt); end
        end
        flush = 1'b1;
        tick();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL flush_stall_valid got=%b exp=0", wb_valid); end
        checks++; if (rf_wr_en !== 1'b0) begin failures++; $display("FAIL flush_stall_wr_en got=%b exp=0", rf_wr_en); end
        checks++; if (cnt !== 4'd2) begin failures++; $display("FAIL flush_stall_cnt got=%0d exp=2", cnt); end
        stall = 1'b0; flush = 1'b0;
        idle();
        tick();
        checks++; if (cnt !== 4'd2) begin failures++; $display("FAIL flushed_not_counted got=%0d exp=2", cnt); end
    endtask

    task automatic test_branch();
        drive(1'b1, 2'b10, 5'd1, 1'b1, 32'h5555, 32'h6666, 32'h80, 1'b1, IA_SEL_BRANCH);
        tick();
        idle();
        checks++; if (pc_redirect !== 1'b1) begin failures++; $display("FAIL br_redirect got=%b exp=1", pc_redirect); end
        checks++; if (redirect_pc !== 32'h80) begin failures++; $display("FAIL br_redirect_pc got=%h exp=80", redirect_pc); end
        checks++; if (ia_sel_o !== IA_SEL_BRANCH) begin failures++; $display("FAIL br_ia_sel got=%0d exp=1", ia_sel_o); end
        checks++; if (rf_wr_data !== 32'h80) begin failures++; $display("FAIL jal_wr_data got=%h exp=80", rf_wr_data); end
        tick();
        checks++; if (pc_redirect !== 1'b0) begin failures++; $display("FAIL br_redirect_drop got=%b exp=0", pc_redirect); end
        checks++; if (cnt !== 4'd3) begin failures++; $display("FAIL br_cnt got=%0d exp=3", cnt); end
    endtask

    task automatic test_rsvd_sel();
        drive(1'b1, 2'b11, 5'd4, 1'b1, 32'h1357, 32'h2468, 32'h100, 1'b0, IA_SEL_PC4);
        tick();
        idle();
        checks++; if (rf_wr_data !== 32'h0) begin failures++; $display("FAIL rsvd_wr_data got=%h exp=0", rf_wr_data); end
        checks++; if (rf_wr_en !== 1'b1) begin failures++; $display("FAIL rsvd_wr_en got=%b exp=1", rf_wr_en); end
        tick();
        checks++; if (cnt !== 4'd4) begin failures++; $display("FAIL rsvd_cnt got=%0d exp=4", cnt); end
    endtask

    task automatic test_back_to_back_wrap();
        // 12 back-to-back entries: the first tick only captures, the next 11 each retire one (4 -> 15).
        drive(1'b1, 2'b00, 5'd2, 1'b1, 32'h7, 32'h0, 32'h0, 1'b0, IA_SEL_PC4);
        for (int i = 0; i < 12; i++) tick();
        checks++; if (cnt !== 4'hF) begin failures++; $display("FAIL wrap_pre_cnt got=%0d exp=15", cnt); end
        idle();
        tick();
        checks++; if (cnt !== 4'd0) begin failures++; $display("FAIL wrap_cnt got=%0d exp=0", cnt); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 2'b00, 5'd6, 1'b1, 32'h77, 32'h0, 32'h40, 1'b1, IA_SEL_JALR);
        tick();
        tick();
        checks++; if (cnt !== 4'd1) begin failures++; $display("FAIL pre_rst_cnt got=%0d exp=1", cnt); end
        rst = 1'b1; stall = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        idle();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", wb_valid); end
        checks++; if (rf_wr_data !== 32'h0) begin failures++; $display("FAIL rst_mid_wr_data got=%h exp=0", rf_wr_data); end
        checks++; if (rf_wr_addr !== 5'd0) begin failures++; $display("FAIL rst_mid_wr_addr got=%0d exp=0", rf_wr_addr); end
        checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL rst_mid_redirect_pc got=%h exp=0", redirect_pc); end
        checks++; if (ia_sel_o !== IA_SEL_PC4) begin failures++; $display("FAIL rst_mid_ia_sel got=%0d exp=0", ia_sel_o); end
        checks++; if (cnt !== 4'd0) begin failures++; $display("FAIL rst_mid_cnt got=%0d exp=0", cnt); end
        tick();
        checks++; if (cnt !== 4'd0) begin failures++; $display("FAIL rst_mid_discard got=%0d exp=0", cnt); end
    endtask

`ifdef KAMUS_WB_FWD_EN
    task automatic test_fwd();
        drive(1'b1, 2'b00, 5'd7, 1'b1, 32'h55, 32'h0, 32'h0, 1'b0, IA_SEL_PC4);
        tick();
        idle();
        checks++; if (fwd_valid !== 1'b0) begin failures++; $display("FAIL fwd_early got=%b exp=0", fwd_valid); end
        tick();
        checks++; if (fwd_valid !== 1'b1) begin failures++; $display("FAIL fwd_valid got=%b exp=1", fwd_valid); end
        checks++; if (fwd_rd !== 5'd7) begin failures++; $display("FAIL fwd_rd got=%0d exp=7", fwd_rd); end
        checks++; if (fwd_data !== 32'h55) begin failures++; $display("FAIL fwd_data got=%h exp=55", fwd_data); end
        tick();
        checks++; if (fwd_valid !== 1'b0) begin failures++; $display("FAIL fwd_drop got=%b exp=0", fwd_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_alu_write();
        test_x0();
        test_stall_flush();
        test_branch();
        test_rsvd_sel();
        test_back_to_back_wrap();
        test_reset_mid();
`ifdef KAMUS_WB_FWD_EN
        test_fwd();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kamus_wb.md
# kamus_wb

Write-back stage of the kamus-v pipeline, directly downstream of the memory stage. Captures the memory stage outputs in a MEM/WB register with a valid bit, stall and flush. Selects the write-back value and drives the register-file write port. Forwards branch and redirect information to PC select and keeps a retired-instruction counter.

## Interface
Parameters:
- `CNT_W`, default 64: width of the retired-instruction counter.

Ports:
- `clk_i`, input, 1: core clock; all state updates on the rising edge.
- `rst_i`, input, 1: synchronous, active-high reset.
- `stall_i`, input, 1: hold the MEM/WB register contents.
- `flush_i`, input, 1: invalidate the entry being captured.
- `valid_i`, input, 1: the memory stage holds a real instruction.
- `ex_rslt_i`, input, 32: ALU result.
- `l1d_rd_data_i`, input, 32: load data, already extended by the load/store unit.
- `wb_mux_sel_i`, input, 2: write-back source select.
- `rd_addr_i`, input, 5: destination register.
- `regfile_wr_en_i`, input, 1: instruction writes rd.
- `next_pc_i`, input, 32: PC+4 or branch target.
- `is_branch_taken_i`, input, 1: branch or jump taken.
- `instr_addr_sel_i`, input, `instr_addr_sel_state_e`: PC source select.
- `rf_wr_en_o`, output, 1: register-file write strobe.
- `rf_wr_addr_o`, output, 5: register-file write address.
- `rf_wr_data_o`, output, 32: register-file write data.
- `pc_redirect_o`, output, 1: valid entry with a taken branch.
- `redirect_pc_o`, output, 32: registered `next_pc`.
- `instr_addr_sel_o`, output, `instr_addr_sel_state_e`: registered PC select.
- `wb_valid_o`, output, 1: the MEM/WB entry is valid.
- `retired_cnt_o`, output, `CNT_W`: count of retired instructions.
- `fwd_valid_o`, output, 1: forwarding entry valid. Present only with the forwarding macro.
- `fwd_rd_addr_o`, output, 5: forwarding destination register. Present only with the forwarding macro.
- `fwd_data_o`, output, 32: forwarding data. Present only with the forwarding macro.

## Operation
- MEM/WB register: captures all `*_i` signals plus `valid_i` on every edge unless `stall_i` is high.
- Flush: when `flush_i` is high, the captured valid bit is 0 and payload fields are don't-care.
- Flush has priority over stall: `flush_i` and `stall_i` together clear valid.
- Write-back mux, applied to the registered fields:
  - `WB_ALU` (2'b00): `ex_rslt`.
  - `WB_MEM` (2'b01): `l1d_rd_data`.
  - `WB_PC4` (2'b10): `next_pc`.
  - 2'b11: 32'h0.
- `rf_wr_en_o` = valid & `regfile_wr_en` & (rd != 0). A write to x0 is never issued.
- `rf_wr_addr_o` and `rf_wr_data_o` follow the registered fields regardless of the enable.
- `pc_redirect_o` = valid & `is_branch_taken`.
- `instr_addr_sel_o` and `redirect_pc_o` are direct register outputs.
- Retired counter:
  - Increments by 1 on every edge where the entry is valid and `stall_i` is low; each instruction is counted once.
  - Wraps from all-ones to 0.
  - Is not affected by flush of the incoming entry.

## Timing
- Latency: MEM inputs appear on `rf_*`, `pc_*` and `instr_addr_sel_o` one cycle after capture.
- The register-file write happens on the following edge, inside the register file.
- Stall: outputs hold their values; `rf_wr_en_o` stays asserted during a stall. Because the register file rewrites the same value, this is harmless.
- Reset at the edge where `rst_i` is high:
  - valid = 0; all payload = 0.
  - `instr_addr_sel_o` = first enumerator of `instr_addr_sel_state_e`.
  - `retired_cnt_o` = 0; all `rf_*`, `pc_*` and `fwd_*` outputs = 0.
- Reset mid-stall or mid-flush: reset wins and the entry is discarded.

## Configuration
- `KAMUS_WB_FWD_EN` defined:
  - One-entry last-write buffer, captured on each edge where `rf_wr_en_o` is high and `stall_i` is low.
  - `fwd_*_o` present this buffer for exactly one cycle after the write. This covers the regfile write-then-read hazard for a decode read in the same cycle.
  - Cleared by reset and by `flush_i`.
- `KAMUS_WB_FWD_EN` undefined: no buffer is built and the `fwd_*` ports are absent.

## Structure
- `kamus_pkg` holds:
  - `wb_sel_e` with `WB_ALU`, `WB_MEM`, `WB_PC4`, `WB_RSVD`.
  - `instr_addr_sel_state_e`.
  - `KAMUS_CNT_W` = 64.
- One sub-module, `kamus_memwb_reg`: the parameterised payload register with valid, stall and flush. The write-back mux, counter and forwarding buffer stay in `kamus_wb`.

## Test plan
- ALU write: valid, sel=00, rd=5, ex_rslt=0x1234, wr_en=1 → next cycle `rf_wr_en_o`=1, addr=5, data=0x1234, `retired_cnt_o`=1.
- x0 suppression: rd=0, wr_en=1 → `rf_wr_en_o`=0 and the counter still increments.
- Stall and flush:
  - Capture load data 0xDEADBEEF, sel=01, then `stall_i` for 3 cycles → outputs hold and the counter does not advance.
  - `flush_i` together with stall → `wb_valid_o`=0 next cycle.
- Branch: `is_branch_taken_i`=1, `next_pc_i`=0x80 → `pc_redirect_o`=1, `redirect_pc_o`=0x80 one cycle later.
  - JAL with sel=10 → `rf_wr_data_o`=next_pc.
- Wrap: force the counter to all-ones, then retire one instruction → `retired_cnt_o`=0.
  - Assert `rst_i` mid-stream → all outputs 0 on the next cycle.
- With `KAMUS_WB_FWD_EN`: write x7=0x55 → `fwd_valid_o`=1, `fwd_rd_addr_o`=7, `fwd_data_o`=0x55 for one cycle after the write, then `fwd_valid_o`=0.
